// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter slice: BCD digit geometry,
// default sizing and the gate-controller phase encoding.
package freq_meter_pkg;

    localparam int unsigned BCD_W               = 4;
    localparam logic [BCD_W-1:0] BCD_MAX        = 4'd9;
    localparam int unsigned DEFAULT_DIGITS      = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Phase encoding driven by the 1 Hz gate controller.
    typedef enum logic [1:0] {
        GATE_CLEAR = 2'd0,
        GATE_COUNT = 2'd1,
        GATE_LATCH = 2'd2
    } gate_phase_e;

    function automatic logic is_max(input logic [BCD_W-1:0] d);
        return d == BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear, increment on inc_in, carry when
// incrementing from 9.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc_in) begin
            digit <= is_max(digit) ? '0 : digit + 1'b1;
        end
    end

    assign carry_out = inc_in & is_max(digit);

endmodule

// File: rtl/freq_count_latch.sv
// Frequency-meter counter/latch: synchronises sig_in and the gate phases,
// counts sig_in rising edges in saturating BCD, latches on lock rise.
module freq_count_latch
    import freq_meter_pkg::*;
#(
    parameter int unsigned DIGITS      = DEFAULT_DIGITS,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sig_in,
    input  logic                    enable,
    input  logic                    cnt_clr_n,
    input  logic                    lock,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    overflow_out,
    output logic                    valid
);

    localparam int unsigned CW = BCD_W * DIGITS;

    // Synchroniser lanes: {lock, cnt_clr_n, enable, sig_in}
    logic [3:0]    sync_q [SYNC_STAGES];
    logic [3:0]    sync_s;
    logic          sig_d;
    logic          lock_d;
    logic [1:0]    warm;
    logic          armed;
    logic          sig_rise;
    logic          lock_rise;
    logic          clr;
    logic          inc_req;
    logic          all_nines;
    logic [DIGITS:0] carry;
    logic [CW-1:0] count;
    logic          ovf;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sig_d  <= 1'b0;
            lock_d <= 1'b0;
            warm   <= '0;
        end else begin
            sync_q[0] <= {lock, cnt_clr_n, enable, sig_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sig_d  <= sync_s[0];
            lock_d <= sync_s[3];
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    // Edges are ignored until the delayed copies have caught up after reset.
    assign armed     = (warm == 2'd3);
    assign sig_rise  = armed & sync_s[0] & ~sig_d;
    assign lock_rise = armed & sync_s[3] & ~lock_d;
    assign clr       = ~sync_s[2];
    assign inc_req   = sync_s[1] & sig_rise;

    always_comb begin
        all_nines = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            all_nines = all_nines & is_max(count[d*BCD_W +: BCD_W]);
        end
    end

    // Increment is withheld at all-9s so the count saturates instead of wrapping.
    assign carry[0] = inc_req & ~all_nines;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr),
            .inc_in    (carry[g]),
            .digit     (count[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if ((inc_req & all_nines) | carry[DIGITS]) begin
            ovf <= 1'b1;
        end
    end

    // Register reads count/ovf before this edge's update, so a coincident
    // increment or clear is not captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bcd_out      <= '0;
            overflow_out <= 1'b0;
            valid        <= 1'b0;
        end else begin
            valid <= lock_rise;
            if (lock_rise) begin
                bcd_out      <= count;
                overflow_out <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_freq_count_latch.sv
// Directed/randomised bench for freq_count_latch against an integer-count
// reference model.
module tb_freq_count_latch;

    localparam int unsigned DIGITS = 4;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;
    logic        enable;
    logic        cnt_clr_n;
    logic        lock;
    logic [15:0] bcd_out;
    logic        overflow_out;
    logic        valid;

    int total = 0;
    int bad   = 0;
    int model_count = 0;
    bit model_ovf   = 1'b0;
    bit model_en    = 1'b0;

    always #5 clk = ~clk;

    freq_count_latch #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .enable       (enable),
        .cnt_clr_n    (cnt_clr_n),
        .lock         (lock),
        .bcd_out      (bcd_out),
        .overflow_out (overflow_out),
        .valid        (valid)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sig_in period; the model counts it if the gate is open.
    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk);
        if (model_en) begin
            if (model_count == MAXV) model_ovf = 1'b1;
            else model_count++;
        end
    endtask

    task automatic pulses(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) pulse(int'($urandom_range(2, 3)), int'($urandom_range(2, 3)));
            else pulse(2, 2);
        end
    endtask

    task automatic latch_check(input string tag);
        logic [15:0] exp_b;
        logic        exp_o;
        exp_b = to_bcd(model_count);
        exp_o = model_ovf;
        lock = 1'b1;
        @(posedge clk) #1 check({tag, "_valid_e1"}, 32'(valid), 32'd0);
        @(posedge clk) #1 check({tag, "_valid_e2"}, 32'(valid), 32'd0);
        @(posedge clk) #1;
        check({tag, "_valid_e3"}, 32'(valid), 32'd1);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_b));
        check({tag, "_ovf"}, 32'(overflow_out), 32'(exp_o));
        @(posedge clk) #1 check({tag, "_valid_e4"}, 32'(valid), 32'd0);
        @(negedge clk);
        tick(3);
        check({tag, "_no_relatch"}, 32'(valid), 32'd0);
        lock = 1'b0;
        tick(4);
    endtask

    task automatic clear_phase(input int n);
        cnt_clr_n   = 1'b0;
        model_count = 0;
        model_ovf   = 1'b0;
        tick(n);
        cnt_clr_n = 1'b1;
        tick(3);
    endtask

    task automatic window(input int n, input bit rnd, input string tag);
        clear_phase(4);
        enable = 1'b1;
        tick(3);
        model_en = 1'b1;
        pulses(n, rnd);
        model_en = 1'b0;
        enable = 1'b0;
        tick(4);
        latch_check(tag);
    endtask

    initial begin
        logic [15:0] held;

        // Reset with every input high
        reset = 1'b0; sig_in = 1'b1; enable = 1'b1; cnt_clr_n = 1'b1; lock = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #1;
            check("warm_valid", 32'(valid), 32'd0);
            check("warm_bcd", 32'(bcd_out), 32'd0);
        end
        @(negedge clk);
        sig_in = 1'b0; lock = 1'b0; enable = 1'b0;
        tick(4);
        latch_check("no_spurious");

        window(1234, 1'b1, "w1234");
        window(9, 1'b1, "w9");
        window(99, 1'b1, "w99");
        window(999, 1'b1, "w999");
        window(1000, 1'b1, "w1000");
        window(10005, 1'b0, "w_ovf");
        window(5, 1'b1, "w_after_ovf");
        window(int'($urandom_range(1, 300)), 1'b1, "w_rand");

        // Gated pulses are ignored; latched value survives the next clear/count
        clear_phase(4);
        pulses(20, 1'b1);
        enable = 1'b1;
        tick(3);
        model_en = 1'b1;
        pulses(7, 1'b1);
        model_en = 1'b0;
        enable = 1'b0;
        tick(4);
        latch_check("gated7");
        held = to_bcd(model_count);
        cnt_clr_n = 1'b0;
        model_count = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk) #1;
            check("hold_clear_bcd", 32'(bcd_out), 32'(held));
            check("hold_clear_valid", 32'(valid), 32'd0);
        end
        @(negedge clk) cnt_clr_n = 1'b1;
        enable = 1'b1;
        tick(3);
        pulses(4, 1'b1);
        enable = 1'b0;
        check("hold_count_bcd", 32'(bcd_out), 32'(held));

        // Reset mid-window with lock held high
        clear_phase(4);
        enable = 1'b1;
        tick(3);
        model_en = 1'b1;
        pulses(50, 1'b1);
        lock = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_valid", 32'(valid), 32'd1);
        check("mid_bcd", 32'(bcd_out), 32'(to_bcd(model_count)));
        @(negedge clk) reset = 1'b0;
        model_count = 0;
        model_ovf = 1'b0;
        @(posedge clk) #1;
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_ovf", 32'(overflow_out), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk) #1;
            check("rel_lock_high_valid", 32'(valid), 32'd0);
        end
        @(negedge clk);
        pulses(3, 1'b1);
        model_en = 1'b0;
        enable = 1'b0;
        tick(4);
        lock = 1'b0;
        tick(4);
        latch_check("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
